// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//   Boot-time sequencer for the instruction SRAM. Consumes a little-endian
//   byte stream (4-byte word count N, then N 4-byte words), assembles 32-bit
//   words and writes each one through the debug_imem_* port with a
//   setup / strobe / hold sequence. The core is held in reset (cpu_rst)
//   until the whole image has been written.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   reload            1-cycle pulse, restarts loading from DONE or ERR
//   in_valid/in_data  byte stream input
//   in_ready          byte accepted when in_valid & in_ready
//   cpu_rst           core reset, 1 while loading or in error
//   debug_imem_oe     SRAM output enable (active-low), 0 only when done
//   debug_imem_we     SRAM write enable (active-low)
//   debug_imem_addr   SRAM word address
//   debug_imem_data   SRAM write data
//   done              image fully written, core released
//   err               header word count exceeded MAX_WORDS
// ---------------------------------------------------------------------------
module imem_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          MAX_WORDS = 65536,
    parameter int          WE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reload,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        cpu_rst,
    output logic        debug_imem_oe,
    output logic        debug_imem_we,
    output logic [31:0] debug_imem_addr,
    output logic [31:0] debug_imem_data,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_HDR    = 3'd0;
    localparam logic [2:0] S_DATA   = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_STROBE = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam int              SW          = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [SW-1:0]   STROBE_LAST = SW'(WE_CYCLES - 1);
    localparam logic [32:0]     MAX_N       = 33'(MAX_WORDS);

    logic [2:0]    state;
    logic [1:0]    byte_cnt;
    logic [31:0]   hdr_n;       // word count N from the header
    logic [23:0]   word_buf;    // lower three bytes of the word being assembled
    logic [31:0]   idx;         // index of the word currently being loaded
    logic [SW-1:0] strobe_cnt;

    // Full 32-bit values as they stand once the 4th byte arrives.
    logic [31:0] hdr_full;
    logic [31:0] word_full;
    logic [31:0] idx_next;

    assign hdr_full  = {in_data, hdr_n[23:0]};
    assign word_full = {in_data, word_buf};
    assign idx_next  = idx + 32'd1;

    // Ready depends on state only so a source may wait for ready before valid.
    assign in_ready = !rst && (state == S_HDR || state == S_DATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_HDR;
            byte_cnt        <= 2'd0;
            hdr_n           <= 32'd0;
            word_buf        <= 24'd0;
            idx             <= 32'd0;
            strobe_cnt      <= '0;
            cpu_rst         <= 1'b1;
            debug_imem_oe   <= 1'b1;
            debug_imem_we   <= 1'b1;
            debug_imem_addr <= BASE_ADDR;
            debug_imem_data <= 32'd0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            case (state)
                S_HDR: begin
                    if (in_valid) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0:    hdr_n[7:0]   <= in_data;
                            2'd1:    hdr_n[15:8]  <= in_data;
                            2'd2:    hdr_n[23:16] <= in_data;
                            default: hdr_n        <= hdr_full;
                        endcase
                        if (byte_cnt == 2'd3) begin
                            idx <= 32'd0;
                            if (hdr_full == 32'd0) begin
                                state         <= S_DONE;
                                cpu_rst       <= 1'b0;
                                debug_imem_oe <= 1'b0;
                                done          <= 1'b1;
                            end else if ({1'b0, hdr_full} > MAX_N) begin
                                state <= S_ERR;
                                err   <= 1'b1;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end

                S_DATA: begin
                    if (in_valid) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0:    word_buf[7:0]   <= in_data;
                            2'd1:    word_buf[15:8]  <= in_data;
                            2'd2:    word_buf[23:16] <= in_data;
                            default: ;
                        endcase
                        // Address/data are only loaded here, so they stay
                        // stable across setup, strobe and hold.
                        if (byte_cnt == 2'd3) begin
                            debug_imem_addr <= BASE_ADDR + idx;
                            debug_imem_data <= word_full;
                            state           <= S_SETUP;
                        end
                    end
                end

                S_SETUP: begin
                    debug_imem_we <= 1'b0;
                    strobe_cnt    <= '0;
                    state         <= S_STROBE;
                end

                S_STROBE: begin
                    if (strobe_cnt == STROBE_LAST) begin
                        debug_imem_we <= 1'b1;
                        state         <= S_HOLD;
                    end else begin
                        strobe_cnt <= strobe_cnt + 1'b1;
                    end
                end

                S_HOLD: begin
                    idx <= idx_next;
                    if (idx_next == hdr_n) begin
                        state         <= S_DONE;
                        cpu_rst       <= 1'b0;
                        debug_imem_oe <= 1'b0;
                        done          <= 1'b1;
                    end else begin
                        state <= S_DATA;
                    end
                end

                S_DONE, S_ERR: begin
                    if (reload) begin
                        state         <= S_HDR;
                        byte_cnt      <= 2'd0;
                        hdr_n         <= 32'd0;
                        idx           <= 32'd0;
                        cpu_rst       <= 1'b1;
                        debug_imem_oe <= 1'b1;
                        done          <= 1'b0;
                        err           <= 1'b0;
                    end
                end

                default: state <= S_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          MAXW = 65536;
    localparam int          WEC  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reload = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        cpu_rst;
    logic        oe;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        done;
    logic        err;

    imem_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .WE_CYCLES(WEC)) dut (
        .clk(clk), .rst(rst), .reload(reload),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cpu_rst(cpu_rst), .debug_imem_oe(oe), .debug_imem_we(we),
        .debug_imem_addr(addr), .debug_imem_data(data),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    wr_t exp_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic        prev_we = 1'b1;
    int          low_cnt = 0;
    int          wr_seen = 0;
    logic [31:0] cap_a, cap_d;

    always @(negedge clk) begin
        wr_t e;
        if (rst) begin
            prev_we = 1'b1;
            low_cnt = 0;
        end else begin
            if (!we) begin
                chk("oe_high_during_we", oe, 1);
                chk("in_ready_low_during_we", in_ready, 0);
                if (prev_we) begin
                    low_cnt = 1;
                    cap_a   = addr;
                    cap_d   = data;
                end else begin
                    low_cnt++;
                    chk("addr_stable", addr, cap_a);
                    chk("data_stable", data, cap_d);
                end
            end else if (!prev_we) begin
                wr_seen++;
                chk("we_low_cycles", low_cnt, WEC);
                chk("hold_addr", addr, cap_a);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", cap_a, e.a);
                    chk("write_data", cap_d, e.d);
                end
            end
            prev_we = we;
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget;
        bit ok;
        while (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        budget   = 50;
        ok       = 1'b0;
        while (!ok && budget > 0) begin
            ok = in_ready;
            @(negedge clk);
            budget--;
        end
        in_valid = 1'b0;
        if (!ok) chk("byte_accept_timeout", 0, 1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
    endtask

    // Reference model: word i of an image lands at BASE+i with its value.
    task automatic load(input int n, input bit gaps);
        logic [31:0] w;
        send_word(32'(n), gaps);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            exp_q.push_back('{BASE + 32'(i), w});
            send_word(w, gaps);
        end
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk({nm, "_done"}, done, 1);
        chk({nm, "_cpu_rst"}, cpu_rst, 0);
        chk({nm, "_oe"}, oe, 0);
        chk({nm, "_we"}, we, 1);
        chk({nm, "_pending_writes"}, exp_q.size(), 0);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        chk("reload_in_ready", in_ready, 1);
        chk("reload_done", done, 0);
        chk("reload_err", err, 0);
        chk("reload_cpu_rst", cpu_rst, 1);
        chk("reload_oe", oe, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int seen;
        logic [31:0] w0, w1;

        // 1: async reset with no clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_we", we, 1);
        chk("rst_oe", oe, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_addr", addr, BASE);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rel_in_ready", in_ready, 1);
        @(negedge clk);

        // 2: two-word image from fixed stream
        send_word(32'd2, 1'b0);
        exp_q.push_back('{BASE, 32'h0000_0013});
        exp_q.push_back('{BASE + 32'd1, 32'h0010_0093});
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_0093, 1'b0);
        wait_done("img2");

        // bytes offered in DONE are not consumed
        in_valid = 1'b1;
        in_data  = 8'hAA;
        @(negedge clk);
        chk("done_in_ready", in_ready, 0);
        in_valid = 1'b0;

        // 3: N=0 -> DONE one cycle after 4th byte, no write
        pulse_reload();
        seen = wr_seen;
        send_word(32'd0, 1'b0);
        chk("n0_done", done, 1);
        chk("n0_cpu_rst", cpu_rst, 0);
        @(negedge clk);
        chk("n0_no_write", wr_seen, seen);

        // 4: N=65537 -> ERR, sticky until reload
        pulse_reload();
        send_word(32'd65537, 1'b0);
        chk("err_flag", err, 1);
        chk("err_cpu_rst", cpu_rst, 1);
        chk("err_oe", oe, 1);
        chk("err_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1);
        chk("err_no_write", wr_seen, seen);
        pulse_reload();
        load(5, 1'b0);
        wait_done("after_err");

        // 5: same fixed image with random in_valid gaps
        pulse_reload();
        send_word(32'd2, 1'b1);
        exp_q.push_back('{BASE, 32'h0000_0013});
        exp_q.push_back('{BASE + 32'd1, 32'h0010_0093});
        send_word(32'h0000_0013, 1'b1);
        send_word(32'h0010_0093, 1'b1);
        wait_done("gaps");

        // random images
        repeat (3) begin
            pulse_reload();
            load(int'($urandom_range(1, 6)), 1'b1);
            wait_done("rand");
        end

        // N == MAX_WORDS is legal (enters DATA); recover with rst
        pulse_reload();
        send_word(32'(MAXW), 1'b0);
        chk("max_no_err", err, 0);
        chk("max_in_ready", in_ready, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 6: rst during STROBE of word 1
        w0 = $urandom;
        w1 = $urandom;
        send_word(32'd2, 1'b0);
        exp_q.push_back('{BASE, w0});
        send_word(w0, 1'b0);
        send_word(w1, 1'b0);
        @(negedge clk);
        chk("strobe_w1_we_low", we, 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_we", we, 1);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_cpu_rst", cpu_rst, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_rel_in_ready", in_ready, 1);
        chk("midrst_rel_done", done, 0);
        chk("midrst_w0_written", exp_q.size(), 0);
        @(negedge clk);
        load(4, 1'b1);
        wait_done("after_midrst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
